mem2_access_ctrl: RTL and testbench
===================================

# mem2_access_ctrl

Memory-access controller for the MEM2 stage of the 6-stage pipeline. It consumes the control and data outputs of the MEM1/MEM2 pipeline register, performs loads and stores on an external single-port data SRAM through a request/acknowledge handshake, and freezes the pipeline until each access completes. It presents write-back-ready values to the MEM2/WB register, inserting bubbles while frozen, and flags SRAM accesses that time out.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 16: SRAM word-address width.
- TIMEOUT, 255: maximum wait cycles for `sram_ack`; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- WB_EN, MEM_R_EN, MEM_W_EN  in  1 each  control from the MEM1/MEM2 register.
- ALURes  in  32  effective byte address, or the ALU result for non-memory ops.
- STVal  in  32  store data.
- dest  in  5  destination register.
- sram_req  out  1  access request.
- sram_we  out  1  1 = write, 0 = read.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data; valid when `sram_ack` is high.
- sram_ack  in  1  single-cycle completion pulse.
- freeze  out  1  holds the PC and every upstream pipeline register, including MEM1/MEM2.
- WB_EN_OUT, MEM_R_EN_OUT  out  1 each  to the MEM2/WB register.
- ALURes_OUT  out  32  ALURes passthrough.
- memData_OUT  out  32  load data.
- dest_OUT  out  5  dest passthrough.
- bus_err  out  1  sticky timeout flag.

## Operation
- State machine with three states: IDLE, BUSY, DONE.
- A memory op is MEM_R_EN | MEM_W_EN. If both are high, the access is a read and the write is suppressed.
- IDLE:
  - No memory op: pure passthrough, `freeze` = 0.
  - Memory op: `freeze` = 1 (combinational), and the controller latches the following, then goes to BUSY:
    - `sram_addr` = ((ALURes − BASE_ADDR) >> 2) truncated to ADDR_W bits; address wraps modulo 2^ADDR_W with no error.
    - `sram_wdata` = STVal.
    - `sram_we` = MEM_W_EN & ~MEM_R_EN.
- BUSY:
  - `sram_req` = 1 and `freeze` = 1.
  - `sram_addr`, `sram_we` and `sram_wdata` stay stable.
  - The wait counter increments each cycle.
  - On `sram_ack` = 1: register `sram_rdata` into `memData_OUT` (reads only; writes leave it unchanged), then go to DONE.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT with no ack: set `bus_err`, load `memData_OUT` = 0, go to DONE.
- DONE:
  - `freeze` = 0 and `sram_req` = 0.
  - The completed op is still present on the inputs; it is passed to WB, and the MEM1/MEM2 register advances at this edge.
  - Always returns to IDLE; the op is never re-issued.
- Output rules:
  - WB_EN_OUT = WB_EN & ~freeze.
  - MEM_R_EN_OUT = MEM_R_EN & ~freeze. A frozen cycle is a bubble to WB.
  - ALURes_OUT and dest_OUT are passthrough.
- `sram_ack` outside BUSY is ignored.
- `bus_err` clears only on reset.

## Timing
- Reset (rst = 0, asynchronous):
  - State returns to IDLE and the wait counter clears.
  - `sram_req`, `sram_we`, `sram_addr`, `sram_wdata`, `memData_OUT` and `bus_err` = 0 immediately.
  - `freeze`, WB_EN_OUT and MEM_R_EN_OUT are forced to 0 while rst = 0.
- Reset mid-access: `sram_req` drops without waiting for ack; the access is abandoned.
- Zero-wait SRAM (ack in the first BUSY cycle): op presented at T, `freeze` high at T and T+1, `sram_req` high at T+1, DONE at T+2. That is 3 cycles in MEM2, 2 stall cycles.
- N-cycle ack delay: the op takes N + 3 cycles and `freeze` is high for N + 2 cycles.
- Timeout: `sram_req` is high for exactly TIMEOUT cycles; `bus_err` rises on the edge entering DONE.
- Back-to-back memory ops: the second op is seen in the IDLE cycle after DONE, giving 3 cycles per op minimum.
- Non-memory ops: 1 cycle, no freeze.

## Test plan
- Reset: rst low mid-BUSY. Expect `sram_req` = 0, `freeze` = 0, `bus_err` = 0 asynchronously; after release, state is IDLE.
- Load, zero-wait: ALURes = 1032, MEM_R_EN = 1, dest = 7, ack in the first BUSY cycle with rdata = 0xDEADBEEF.
  - Expect `sram_addr` = 2 and `sram_we` = 0.
  - Expect `freeze` high for 2 cycles.
  - In DONE expect `memData_OUT` = 0xDEADBEEF, MEM_R_EN_OUT = 1, dest_OUT = 7.
- Store, 3-wait: ALURes = 1028, STVal = 0x12345678, MEM_W_EN = 1, ack after 3 BUSY cycles.
  - Expect `sram_we` = 1 and `sram_addr` = 1, with wdata stable for all 4 req cycles.
  - Expect `freeze` high for 5 cycles and WB_EN_OUT = 0 throughout.
- Back-to-back: a load followed by an ALU op (WB_EN = 1, ALURes = 5). Expect the ALU op to reach WB one cycle after the load's DONE, with no re-issue of the load.
- Timeout: TIMEOUT = 4, no ack. Expect `sram_req` high for exactly 4 cycles, then `bus_err` = 1 and `memData_OUT` = 0, with `bus_err` still 1 after the next load.
- Both enables high: MEM_R_EN = MEM_W_EN = 1. Expect `sram_we` = 0, i.e. a read is performed.

Source files
------------

// File: rtl/mem2_access_ctrl.sv
// Purpose : MEM2-stage memory access controller. Issues loads/stores to a
//           single-port data SRAM over a req/ack handshake, freezes the
//           pipeline until each access completes, and feeds the MEM2/WB
//           register (bubbles while frozen). Flags SRAM timeouts via a
//           sticky bus_err.
// Latency : non-memory op 1 cycle; memory op N+3 cycles for an ack after
//           N wait cycles (minimum 3: IDLE -> BUSY -> DONE).
// Backpressure: freeze holds the PC and all upstream registers while an
//           access is being set up or is outstanding. The SRAM stalls us
//           by withholding sram_ack.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   WB_EN, MEM_R_EN, MEM_W_EN     control from MEM1/MEM2 register
//   ALURes, STVal, dest           address / ALU result, store data, dest reg
//   sram_req/we/addr/wdata        SRAM request side (stable while req high)
//   sram_rdata, sram_ack          SRAM completion (ack is a 1-cycle pulse)
//   freeze                        pipeline stall
//   WB_EN_OUT, MEM_R_EN_OUT,
//   ALURes_OUT, memData_OUT,
//   dest_OUT                      values for the MEM2/WB register
//   bus_err                       sticky timeout flag
module mem2_access_ctrl #(
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALURes,
  input  logic [31:0]       STVal,
  input  logic [4:0]        dest,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack,
  output logic              freeze,
  output logic              WB_EN_OUT,
  output logic              MEM_R_EN_OUT,
  output logic [31:0]       ALURes_OUT,
  output logic [31:0]       memData_OUT,
  output logic [4:0]        dest_OUT,
  output logic              bus_err
);

  // Wide enough to hold TIMEOUT; a 1-bit counter when the timeout is off.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_op;
  logic             ack_hit;
  logic             tmo_hit;
  logic             freeze_raw;

  assign mem_op  = MEM_R_EN | MEM_W_EN;
  assign ack_hit = (state == BUSY) && sram_ack;
  // wait_cnt counts completed BUSY cycles, so the TIMEOUT-th BUSY cycle sees
  // TIMEOUT-1; leaving then keeps sram_req high for exactly TIMEOUT cycles.
  // An ack arriving in that same cycle wins over the timeout.
  assign tmo_hit = (TIMEOUT != 0) && (state == BUSY) && !sram_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    freeze_raw = 1'b0;
    sram_req   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          freeze_raw = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        freeze_raw = 1'b1;
        sram_req   = 1'b1;
        if (ack_hit || tmo_hit) begin
          state_nxt = DONE;
        end
      end
      // The op is still on our inputs here and retires to WB; MEM1/MEM2
      // advances on this edge, so we must not look at mem_op again.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The IDLE decode is combinational, so it must be masked during reset
  // or a memory op on the inputs would assert freeze.
  assign freeze = freeze_raw & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      memData_OUT <= '0;
      bus_err     <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      if (state == IDLE && mem_op) begin
        // Byte offset to word index; out-of-range addresses wrap silently.
        sram_addr  <= ADDR_W'((ALURes - 32'(BASE_ADDR)) >> 2);
        sram_wdata <= STVal;
        // A read takes precedence when both enables are set.
        sram_we    <= MEM_W_EN & ~MEM_R_EN;
      end

      if (state == BUSY) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (ack_hit) begin
        if (!sram_we) begin
          memData_OUT <= sram_rdata;
        end
      end else if (tmo_hit) begin
        memData_OUT <= '0;
        bus_err     <= 1'b1;
      end
    end
  end

  // Frozen cycles are bubbles to WB.
  assign WB_EN_OUT    = WB_EN & ~freeze & rst;
  assign MEM_R_EN_OUT = MEM_R_EN & ~freeze & rst;
  assign ALURes_OUT   = ALURes;
  assign dest_OUT     = dest;

endmodule

// File: tb/tb_mem2_access_ctrl.sv
// Purpose : directed self-checking bench for mem2_access_ctrl (TIMEOUT = 4).
// Latency : inputs driven 1 time unit after the rising edge, outputs
//           sampled on the falling edge.
// Backpressure: the bench plays the SRAM and chooses when to pulse sram_ack.
module tb_mem2_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALURes, STVal;
  logic [4:0]  dest;
  logic        sram_req, sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_ack;
  logic        freeze, WB_EN_OUT, MEM_R_EN_OUT;
  logic [31:0] ALURes_OUT, memData_OUT;
  logic [4:0]  dest_OUT;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem2_access_ctrl #(.BASE_ADDR(1024), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALURes(ALURes), .STVal(STVal), .dest(dest),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .freeze(freeze), .WB_EN_OUT(WB_EN_OUT), .MEM_R_EN_OUT(MEM_R_EN_OUT),
    .ALURes_OUT(ALURes_OUT), .memData_OUT(memData_OUT), .dest_OUT(dest_OUT),
    .bus_err(bus_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0;
    ALURes = 0; STVal = 0; dest = 0;
    sram_ack = 0; sram_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1032;
    @(negedge clk);
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", sram_req); end
    n_cmp++; if (freeze !== 1'b0) begin n_bad++; $display("FAIL rst_freeze: got %b want 0", freeze); end
    n_cmp++; if (WB_EN_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_wb_en: got %b want 0", WB_EN_OUT); end
    n_cmp++; if (MEM_R_EN_OUT !== 1'b0) begin n_bad++; $display("FAIL rst_mem_r_en: got %b want 0", MEM_R_EN_OUT); end
    n_cmp++; if ({sram_we, sram_addr, sram_wdata, memData_OUT, bus_err} !== '0) begin
      n_bad++; $display("FAIL rst_regs: we=%b addr=%h wdata=%h mem=%h err=%b want all 0",
                        sram_we, sram_addr, sram_wdata, memData_OUT, bus_err);
    end
    #1 rst = 1;                      // load still on inputs: goes BUSY next edge
    @(negedge clk);
    n_cmp++; if (sram_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy_req: got %b want 1", sram_req); end
    #1 rst = 0;                      // abandon the access mid-BUSY
    #1;
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req: got %b want 0", sram_req); end
    n_cmp++; if (freeze !== 1'b0) begin n_bad++; $display("FAIL rst_mid_freeze: got %b want 0", freeze); end
    n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b want 0", bus_err); end
    n_cmp++; if (sram_addr !== 16'h0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0000", sram_addr); end
    clear_inputs();
    next_cycle();
    rst = 1;
    @(negedge clk);
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL rst_rel_req: got %b want 0", sram_req); end
    next_cycle();
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1032;
    @(negedge clk);                  // IDLE decode: freeze without req
    n_cmp++; if ({freeze, sram_req} !== 2'b10) begin n_bad++; $display("FAIL rst_rel_idle: freeze/req got %b want 10", {freeze, sram_req}); end
    next_cycle();
    sram_ack = 1; sram_rdata = 32'h11111111;
    next_cycle();
    sram_ack = 0;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_load_zero_wait();
    int fcnt = 0;
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1032; dest = 5'd7;
    @(negedge clk);
    if (freeze) fcnt++;
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL ld_idle_req: got %b want 0", sram_req); end
    n_cmp++; if (MEM_R_EN_OUT !== 1'b0) begin n_bad++; $display("FAIL ld_idle_bubble: got %b want 0", MEM_R_EN_OUT); end
    next_cycle();
    sram_ack = 1; sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    if (freeze) fcnt++;
    n_cmp++; if (sram_req !== 1'b1) begin n_bad++; $display("FAIL ld_busy_req: got %b want 1", sram_req); end
    n_cmp++; if (sram_addr !== 16'd2) begin n_bad++; $display("FAIL ld_addr: got %0d want 2", sram_addr); end
    n_cmp++; if (sram_we !== 1'b0) begin n_bad++; $display("FAIL ld_we: got %b want 0", sram_we); end
    next_cycle();
    sram_ack = 0; sram_rdata = 0;
    @(negedge clk);
    if (freeze) fcnt++;
    n_cmp++; if (fcnt !== 2) begin n_bad++; $display("FAIL ld_freeze_cycles: got %0d want 2", fcnt); end
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL ld_done_req: got %b want 0", sram_req); end
    n_cmp++; if (memData_OUT !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_data: got %h want deadbeef", memData_OUT); end
    n_cmp++; if (MEM_R_EN_OUT !== 1'b1) begin n_bad++; $display("FAIL ld_mem_r_en_out: got %b want 1", MEM_R_EN_OUT); end
    n_cmp++; if (dest_OUT !== 5'd7) begin n_bad++; $display("FAIL ld_dest: got %0d want 7", dest_OUT); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1044; dest = 5'd2;
    next_cycle();
    sram_ack = 1; sram_rdata = 32'hA5A5A5A5;
    next_cycle();
    sram_ack = 0;
    @(negedge clk);
    n_cmp++; if (freeze !== 1'b0) begin n_bad++; $display("FAIL b2b_done_freeze: got %b want 0", freeze); end
    next_cycle();                    // MEM1/MEM2 advanced: ALU op arrives
    MEM_R_EN = 0; WB_EN = 1; ALURes = 32'd5; dest = 5'd9;
    @(negedge clk);
    n_cmp++; if ({freeze, sram_req} !== 2'b00) begin n_bad++; $display("FAIL b2b_alu_stall: freeze/req got %b want 00", {freeze, sram_req}); end
    n_cmp++; if ({WB_EN_OUT, MEM_R_EN_OUT} !== 2'b10) begin n_bad++; $display("FAIL b2b_alu_ctl: got %b want 10", {WB_EN_OUT, MEM_R_EN_OUT}); end
    n_cmp++; if (ALURes_OUT !== 32'd5 || dest_OUT !== 5'd9) begin n_bad++; $display("FAIL b2b_alu_data: got %0d/%0d want 5/9", ALURes_OUT, dest_OUT); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL b2b_no_reissue: got %b want 0", sram_req); end
    next_cycle();
  endtask

  task automatic test_store_3wait();
    int fcnt = 0;
    int bad_busy = 0;
    WB_EN = 1; MEM_W_EN = 1; ALURes = 32'd1028; STVal = 32'h12345678;
    @(negedge clk);
    if (freeze) fcnt++;
    n_cmp++; if (WB_EN_OUT !== 1'b0) begin n_bad++; $display("FAIL st_idle_wb: got %b want 0", WB_EN_OUT); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sram_ack = (i == 3);
      @(negedge clk);
      if (freeze) fcnt++;
      n_cmp++;
      if ({sram_req, sram_we, WB_EN_OUT} !== 3'b110 || sram_addr !== 16'd1 || sram_wdata !== 32'h12345678) begin
        n_bad++; bad_busy++;
        $display("FAIL st_busy%0d: req/we/wb=%b addr=%0d wdata=%h want 110/1/12345678",
                 i, {sram_req, sram_we, WB_EN_OUT}, sram_addr, sram_wdata);
      end
    end
    next_cycle();
    sram_ack = 0;
    @(negedge clk);
    if (freeze) fcnt++;
    n_cmp++; if (fcnt !== 5) begin n_bad++; $display("FAIL st_freeze_cycles: got %0d want 5", fcnt); end
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL st_done_req: got %b want 0", sram_req); end
    n_cmp++; if (memData_OUT !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL st_data_kept: got %h want a5a5a5a5", memData_OUT); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    int rcnt = 0;
    int cyc = 0;
    int early = 0;
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1040; dest = 5'd4;
    @(negedge clk);
    while (freeze === 1'b1 && cyc < 20) begin
      next_cycle();
      @(negedge clk);
      cyc++;
      if (sram_req === 1'b1) rcnt++;
      if (freeze === 1'b1 && bus_err !== 1'b0) early++;
    end
    n_cmp++; if (cyc >= 20) begin n_bad++; $display("FAIL to_bound: still frozen after %0d cycles, want release", cyc); end
    n_cmp++; if (rcnt !== 4) begin n_bad++; $display("FAIL to_req_cycles: got %0d want 4", rcnt); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_err_early: bus_err high in %0d busy cycles want 0", early); end
    n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", bus_err); end
    n_cmp++; if (memData_OUT !== 32'h0) begin n_bad++; $display("FAIL to_data: got %h want 0", memData_OUT); end
    next_cycle();
    clear_inputs();
    WB_EN = 1; MEM_R_EN = 1; ALURes = 32'd1024;
    next_cycle();
    sram_ack = 1; sram_rdata = 32'hCAFEF00D;
    next_cycle();
    sram_ack = 0;
    @(negedge clk);
    n_cmp++; if (memData_OUT !== 32'hCAFEF00D) begin n_bad++; $display("FAIL to_next_data: got %h want cafef00d", memData_OUT); end
    n_cmp++; if (bus_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", bus_err); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_both_enables();
    WB_EN = 1; MEM_R_EN = 1; MEM_W_EN = 1; ALURes = 32'd1036; STVal = 32'hFFFFFFFF;
    next_cycle();
    sram_ack = 1; sram_rdata = 32'h0BADF00D;
    @(negedge clk);
    n_cmp++; if (sram_we !== 1'b0) begin n_bad++; $display("FAIL both_we: got %b want 0", sram_we); end
    n_cmp++; if (sram_addr !== 16'd3) begin n_bad++; $display("FAIL both_addr: got %0d want 3", sram_addr); end
    next_cycle();
    sram_ack = 0;
    @(negedge clk);
    n_cmp++; if (memData_OUT !== 32'h0BADF00D) begin n_bad++; $display("FAIL both_data: got %h want 0badf00d", memData_OUT); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_addr_wrap();
    MEM_R_EN = 1; ALURes = 32'd1020;  // one word below BASE_ADDR
    next_cycle();
    sram_ack = 1; sram_rdata = 32'h600DCAFE;
    @(negedge clk);
    n_cmp++; if (sram_addr !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_addr: got %h want ffff", sram_addr); end
    next_cycle();
    sram_ack = 0;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_passthrough();
    WB_EN = 1; ALURes = 32'h1234; dest = 5'd3;
    sram_ack = 1; sram_rdata = 32'h55555555;   // stray ack in IDLE
    @(negedge clk);
    n_cmp++; if ({freeze, sram_req, WB_EN_OUT} !== 3'b001) begin n_bad++; $display("FAIL pt_ctl: freeze/req/wb got %b want 001", {freeze, sram_req, WB_EN_OUT}); end
    n_cmp++; if (ALURes_OUT !== 32'h1234 || dest_OUT !== 5'd3) begin n_bad++; $display("FAIL pt_data: got %h/%0d want 1234/3", ALURes_OUT, dest_OUT); end
    next_cycle();
    sram_ack = 0;
    @(negedge clk);
    n_cmp++; if (memData_OUT !== 32'h600DCAFE) begin n_bad++; $display("FAIL pt_stray_ack: got %h want 600dcafe", memData_OUT); end
    n_cmp++; if (sram_req !== 1'b0) begin n_bad++; $display("FAIL pt_req: got %b want 0", sram_req); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_back_to_back();
    test_store_3wait();
    test_timeout();
    test_both_enables();
    test_addr_wrap();
    test_passthrough();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
